// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Memory end of the CPU's MEM-stage load/store interface. Accepts one load
//   or store per valid/ready handshake, holds a DEPTH-word x 32-bit array and
//   answers after a fixed LATENCY with a one-cycle resp_valid pulse. stall
//   lets the CPU freeze its pipeline while the responder is busy. Misaligned
//   or out-of-range addresses are flagged on err and never touch memory.
//
// Parameters
//   ADDR_W   word-index bits, DEPTH = 2**ADDR_W words
//   LATENCY  clock edges from acceptance to response, 1..15
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   CPU presents a request
//   req_ready   out  responder can accept a request this cycle
//   req_we      in   1 = store, 0 = load
//   adr         in   byte address
//   data_in     in   store data
//   data_out    out  load data, registered, held until the next commit
//   resp_valid  out  one-cycle pulse: request completed
//   err         out  qualifies resp_valid: misaligned or out-of-range request
//   stall       out  req_valid & ~req_ready
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] adr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        resp_valid,
  output logic        err,
  output logic        stall
);

  localparam int DEPTH = 2 ** ADDR_W;
  // BUSY holds for LATENCY-1 cycles; the counter runs LATENCY-2 .. 0.
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      r_state, w_next_state;
  logic [3:0]  r_count, w_next_count;
  logic        r_ready;

  // Request captured at acceptance.
  logic        r_we;
  logic [31:0] r_adr;
  logic [31:0] r_data;

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_data_out;
  logic        r_err;

  logic              w_accept;
  logic              w_commit;
  logic              w_c_we;
  logic [31:0]       w_c_adr;
  logic [31:0]       w_c_data;
  logic              w_c_err;
  logic [ADDR_W-1:0] w_c_idx;

  assign w_accept = req_valid & r_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = (LATENCY == 1) ? RESP : BUSY;
          w_next_count = CNT_INIT;
        end
      end
      BUSY: begin
        if (r_count == 4'd0) w_next_state = RESP;
        else                 w_next_count = r_count - 4'd1;
      end
      RESP: begin
        // Back-to-back accept behaves exactly like an accept from IDLE.
        if (w_accept) begin
          w_next_state = (LATENCY == 1) ? RESP : BUSY;
          w_next_count = CNT_INIT;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Commit: happens on the edge that enters RESP. With LATENCY==1 that is the
  // acceptance edge itself, so the request comes straight from the inputs.
  // ---------------------------------------------------------------------------
  assign w_commit = ((r_state == BUSY) && (r_count == 4'd0)) ||
                    (w_accept && (LATENCY == 1));

  assign w_c_we   = (r_state == BUSY) ? r_we   : req_we;
  assign w_c_adr  = (r_state == BUSY) ? r_adr  : adr;
  assign w_c_data = (r_state == BUSY) ? r_data : data_in;

  assign w_c_err  = (w_c_adr[1:0] != 2'b00) | (w_c_adr[31:ADDR_W+2] != '0);
  assign w_c_idx  = w_c_adr[ADDR_W+1:2];

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_count    <= 4'd0;
      r_ready    <= 1'b0;
      r_we       <= 1'b0;
      r_adr      <= 32'd0;
      r_data     <= 32'd0;
      r_data_out <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
      // Ready is held low in reset and rises on the first edge afterwards.
      r_ready <= (w_next_state != BUSY);

      if (w_accept) begin
        r_we   <= req_we;
        r_adr  <= adr;
        r_data <= data_in;
      end

      if (w_commit) begin
        if (w_c_err) begin
          r_data_out <= 32'd0;
          r_err      <= 1'b1;
        end else begin
          r_err <= 1'b0;
          if (!w_c_we) r_data_out <= r_mem[w_c_idx];
        end
      end
    end
  end

  // NOTE: the memory array has no reset; a write is only possible through a
  // commit, which cannot occur while rst_n is low because the state is IDLE.
  always_ff @(posedge clk) begin
    if (w_commit && w_c_we && !w_c_err) r_mem[w_c_idx] <= w_c_data;
  end

  assign req_ready  = r_ready;
  assign resp_valid = (r_state == RESP);
  assign data_out   = r_data_out;
  assign err        = r_err;
  assign stall      = req_valid & ~r_ready;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Scoreboard bench for dmem_responder. The driver issues requests and, at
//   each acceptance, a reference model (plain word array plus the addressing
//   rules) pushes the expected response and its due cycle into a queue. An
//   independent monitor pops and compares whenever resp_valid is seen, and
//   checks that data_out/err hold between responses.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int ADDR_W = 8;
  localparam int LAT    = 2;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int WORDS  = 16;   // words preloaded and used by random traffic

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] adr = 32'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        resp_valid;
  logic        err;
  logic        stall;

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .adr        (adr),
    .data_in    (data_in),
    .data_out   (data_out),
    .resp_valid (resp_valid),
    .err        (err),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] dout;
    logic        we;
    int          idx;
    logic [31:0] old;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_dout = 32'd0;   // data_out after the latest accepted request
  logic [31:0] seen_dout  = 32'd0;   // data_out after the latest observed response
  logic        seen_err   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: applied in acceptance order.
  task automatic model_accept(input logic we, input logic [31:0] a, input logic [31:0] d, input int due);
    exp_t e;
    e.due = due;
    e.we  = we;
    e.err = (a % 4 != 0) || (a >= 4 * DEPTH);
    e.idx = int'(a / 4);
    e.old = 32'd0;
    if (e.err) begin
      model_dout = 32'd0;
    end else if (we) begin
      e.old = model_mem[e.idx];
      model_mem[e.idx] = d;
    end else begin
      model_dout = model_mem[e.idx];
    end
    e.dout = model_dout;
    q.push_back(e);
  endtask

  // Reset discards pending requests: undo their effect on the model.
  task automatic model_reset();
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].we && !q[i].err) model_mem[q[i].idx] = q[i].old;
    q.delete();
    model_dout = 32'd0;
    seen_dout  = 32'd0;
    seen_err   = 1'b0;
  endtask

  // Presents a request and waits (bounded) for acceptance. With hold=1 the
  // request stays valid so the next call can follow back-to-back.
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d, input bit hold);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    adr       = a;
    data_in   = d;
    n = 0;
    while (!req_ready) begin
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no req_ready expected acceptance of adr %h", a);
        req_valid = 1'b0;
        return;
      end
      n++;
      @(negedge clk);
    end
    model_accept(we, a, d, cyc + LAT);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: independent of the driver.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("resp_cycle", 32'(cyc), 32'(e.due));
          check("resp_data",  data_out, e.dout);
          check("resp_err",   {31'd0, err}, {31'd0, e.err});
          seen_dout = e.dout;
          seen_err  = e.err;
        end
      end else begin
        check("hold_data", data_out, seen_dout);
        check("hold_err",  {31'd0, err}, {31'd0, seen_err});
        if (q.size() > 0 && cyc > q[0].due) begin
          checks++;
          errors++;
          $display("FAIL late_resp: got no resp_valid expected response due at cycle %0d (cycle %0d)", q[0].due, cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    bit          hold;
    int          r;
    int          n;

    // Reset state.
    #2;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp",  {31'd0, resp_valid}, 32'd0);
    check("rst_err",   {31'd0, err}, 32'd0);
    check("rst_data",  data_out, 32'd0);
    req_valid = 1'b1;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd1);
    req_valid = 1'b0;
    idle(3);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Preload the words used below; 0x30 gets a known value.
    for (int i = 0; i < WORDS; i++)
      do_req(1'b1, 32'(i * 4), (i == 12) ? 32'h1111_1111 : $urandom, (i != WORDS - 1));

    // Store then load, and back-to-back store/load.
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 0);
    do_req(1'b0, 32'h10, 32'd0, 0);
    idle(2);
    do_req(1'b1, 32'h20, 32'h1234_5678, 1);
    do_req(1'b0, 32'h20, 32'd0, 0);
    idle(2);

    // Misaligned load, then a good load.
    do_req(1'b0, 32'h12, 32'd0, 0);
    do_req(1'b0, 32'h10, 32'd0, 0);
    // Out-of-range store must not alias onto word 0.
    do_req(1'b1, 32'h400, 32'hFFFF_FFFF, 0);
    do_req(1'b0, 32'h000, 32'd0, 0);
    idle(2);

    // Inputs toggling during BUSY are ignored.
    do_req(1'b1, 32'h3C, 32'hCAFE_F00D, 1);
    for (int i = 0; i < LAT - 1; i++) begin
      @(negedge clk);
      adr     = $urandom;
      data_in = $urandom;
      req_we  = 1'($urandom);
      #1;
      check("busy_stall", {31'd0, stall}, 32'd1);
      check("busy_ready", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    do_req(1'b0, 32'h3C, 32'd0, 0);
    idle(3);

    // Reset during BUSY discards the pending store.
    do_req(1'b1, 32'h30, 32'hAAAA_5555, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_ready", {31'd0, req_ready}, 32'd0);
    check("midrst_resp",  {31'd0, resp_valid}, 32'd0);
    check("midrst_err",   {31'd0, err}, 32'd0);
    check("midrst_data",  data_out, 32'd0);
    idle(2);
    rst_n = 1'b1;
    do_req(1'b0, 32'h30, 32'd0, 0);
    idle(3);
    check("midrst_mem", model_mem[12], 32'h1111_1111);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, WORDS - 1)) * 4;
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      if (r == 1) a = $urandom | 32'h0000_0400;
      hold = (i != 299) && ($urandom_range(0, 1) == 1);
      do_req(1'($urandom), a, $urandom, hold);
      if (!hold) idle($urandom_range(0, 2));
    end

    // Drain.
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d responses outstanding expected 0", q.size());
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
